// File: rtl/bsg_nasti_master_resp.sv
// NASTI read-response packer: buffers R beats and emits them as tunnel
// response packets, checking beat counts against burst lengths from AR.

package bsg_nasti_pkg;
  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } bsg_nasti_r_pkt;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
    logic [5:0]  id;
  } bsg_nasti_sr_pkt;

  typedef logic [$bits(bsg_nasti_sr_pkt)-1:0] bsg_tun_dmx_t;
endpackage

module bsg_nasti_master_resp
  import bsg_nasti_pkg::*;
#(
  parameter int els_p     = 2,
  parameter int len_els_p = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           nasti_r_valid_i,
  input  bsg_nasti_r_pkt nasti_r_data_i,
  output logic           nasti_r_ready_o,
  input  logic           ar_fire_i,
  input  logic [7:0]     ar_len_i,
  output logic           ar_credit_o,
  output logic           resp_valid_o,
  output bsg_tun_dmx_t   resp_data_o,
  input  logic           resp_yumi_i,
  output logic           err_resp_o,
  output logic           err_proto_o
);

  localparam int ptr_w  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w  = $clog2(els_p + 1);
  localparam int lptr_w = (len_els_p > 1) ? $clog2(len_els_p) : 1;
  localparam int lcnt_w = $clog2(len_els_p + 1);

  function automatic logic [ptr_w-1:0] fifo_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  function automatic logic [lptr_w-1:0] lq_inc(input logic [lptr_w-1:0] p);
    return (p == lptr_w'(len_els_p - 1)) ? '0 : p + lptr_w'(1);
  endfunction

  // beat FIFO
  bsg_nasti_sr_pkt    fifo_mem [els_p];
  logic [ptr_w-1:0]   wptr, rptr;
  logic [cnt_w-1:0]   fcount;

  // outstanding-burst length queue
  logic [7:0]         len_mem [len_els_p];
  logic [lptr_w-1:0]  lwptr, lrptr;
  logic [lcnt_w-1:0]  lcount;

  logic [7:0]         cnt_r;
  logic               err_resp_r, err_proto_r;

  logic r_fire, deq, lq_empty, lq_full, lq_push, lq_pop, cnt_at_len;
  logic overflow, proto_evt;
  bsg_nasti_sr_pkt    in_pkt;

  // Ready and valid come from registered counts only; reset forces them low.
  assign nasti_r_ready_o = ~reset_i & (fcount < cnt_w'(els_p));
  assign resp_valid_o    = ~reset_i & (fcount != '0);
  assign resp_data_o     = bsg_tun_dmx_t'(fifo_mem[rptr]);
  assign ar_credit_o     = ~reset_i & ~lq_full;
  assign err_resp_o      = ~reset_i & err_resp_r;
  assign err_proto_o     = ~reset_i & err_proto_r;

  assign r_fire   = nasti_r_valid_i & nasti_r_ready_o;
  assign deq      = resp_yumi_i & resp_valid_o;
  assign lq_empty = (lcount == '0);
  assign lq_full  = (lcount == lcnt_w'(len_els_p));

  assign in_pkt.last = nasti_r_data_i.last;
  assign in_pkt.data = nasti_r_data_i.data;
  assign in_pkt.id   = nasti_r_data_i.id;

  // A burst ends on either a last beat or the expected final beat,
  // whichever comes first; a mismatch between the two is a violation.
  assign cnt_at_len = (cnt_r == len_mem[lrptr]);
  assign lq_pop     = r_fire & ~lq_empty & (nasti_r_data_i.last | cnt_at_len);
  assign lq_push    = ar_fire_i & (~lq_full | lq_pop);
  assign overflow   = ar_fire_i & lq_full & ~lq_pop;
  assign proto_evt  = overflow
                    | (r_fire & lq_empty)
                    | (r_fire & ~lq_empty & (nasti_r_data_i.last != cnt_at_len));

  // beat FIFO storage
  always_ff @(posedge clk_i) begin
    if (r_fire) fifo_mem[wptr] <= in_pkt;
  end

  // beat FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else begin
      if (r_fire) wptr <= fifo_inc(wptr);
      if (deq)    rptr <= fifo_inc(rptr);
      case ({r_fire, deq})
        2'b10:   fcount <= fcount + cnt_w'(1);
        2'b01:   fcount <= fcount - cnt_w'(1);
        default: fcount <= fcount;
      endcase
    end
  end

  // length queue storage
  always_ff @(posedge clk_i) begin
    if (lq_push) len_mem[lwptr] <= ar_len_i;
  end

  // length queue pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lwptr  <= '0;
      lrptr  <= '0;
      lcount <= '0;
    end else begin
      if (lq_push) lwptr <= lq_inc(lwptr);
      if (lq_pop)  lrptr <= lq_inc(lrptr);
      case ({lq_push, lq_pop})
        2'b10:   lcount <= lcount + lcnt_w'(1);
        2'b01:   lcount <= lcount - lcnt_w'(1);
        default: lcount <= lcount;
      endcase
    end
  end

  // beat counter within the current burst; idle while no burst is queued
  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_r <= '0;
    else if (r_fire & ~lq_empty)
      cnt_r <= lq_pop ? 8'd0 : cnt_r + 8'd1;
  end

  // sticky error flags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_resp_r  <= 1'b0;
      err_proto_r <= 1'b0;
    end else begin
      if (r_fire && nasti_r_data_i.resp != 2'b00) err_resp_r <= 1'b1;
      if (proto_evt) err_proto_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_nasti_master_resp.sv
// Scoreboard bench for bsg_nasti_master_resp: directed bursts push expected
// packets; a negedge monitor pops and compares every dequeued packet.

module tb_bsg_nasti_master_resp;
  import bsg_nasti_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           r_valid;
  bsg_nasti_r_pkt r_data;
  logic           r_ready;
  logic           ar_fire;
  logic [7:0]     ar_len;
  logic           ar_credit;
  logic           resp_valid;
  bsg_tun_dmx_t   resp_data;
  logic           resp_yumi;
  logic           err_resp;
  logic           err_proto;
  logic           yumi_en;

  bsg_nasti_master_resp #(.els_p(2), .len_els_p(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .nasti_r_valid_i(r_valid), .nasti_r_data_i(r_data), .nasti_r_ready_o(r_ready),
    .ar_fire_i(ar_fire), .ar_len_i(ar_len), .ar_credit_o(ar_credit),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi),
    .err_resp_o(err_resp), .err_proto_o(err_proto)
  );

  assign resp_yumi = yumi_en & resp_valid;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int n_pkts = 0;
  bit chk_lat = 1'b0;

  typedef struct {
    bsg_tun_dmx_t pkt;
    int           acc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bsg_tun_dmx_t mk(input logic [5:0] id, input logic [63:0] d, input logic l);
    return {l, d, id};
  endfunction

  // monitor: every dequeued packet must match the oldest expected one
  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid && resp_yumi) begin
      n_pkts++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pkt_unexpected: got %0h expected none", resp_data);
      end else begin
        e = sb.pop_front();
        check("pkt_data", 128'(resp_data), 128'(e.pkt));
        if (chk_lat) check("pkt_latency", 128'(cyc), 128'(e.acc));
      end
    end
  end

  // drive one beat, hold until accepted; returns at posedge+1
  task automatic send_beat(input logic [5:0] id, input logic [63:0] d,
                           input logic l, input logic [1:0] resp);
    int n;
    exp_t e;
    n = 0;
    r_valid = 1'b1;
    r_data.id = id; r_data.data = d; r_data.last = l; r_data.resp = resp;
    @(negedge clk);
    while (!r_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!r_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got ready=0 expected ready=1");
    end else begin
      e.pkt = mk(id, d, l);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    r_valid = 1'b0;
  endtask

  task automatic ar(input logic [7:0] len);
    ar_fire = 1'b1;
    ar_len  = len;
    @(posedge clk);
    #1;
    ar_fire = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    r_valid = 1'b0;
    ar_fire = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_outs", 128'({r_ready, ar_credit, resp_valid, err_resp, err_proto}), 128'(0));
    end
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_reset", 128'({r_ready, ar_credit, resp_valid, err_resp, err_proto}), 128'(5'b11000));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    #1;
  endtask

  // 3 pushes must leave room, the 4th must fill: proves queue started empty
  task automatic lq_empty_probe(input string name);
    repeat (3) ar(8'd0);
    check({name, "_credit3"}, 128'(ar_credit), 128'(1));
    ar(8'd0);
    check({name, "_credit4"}, 128'(ar_credit), 128'(0));
  endtask

  initial begin
    int t0, p0;
    reset = 1'b1; r_valid = 1'b0; r_data = '0; ar_fire = 1'b0; ar_len = '0; yumi_en = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // normal burst, full throughput, one-cycle latency
    chk_lat = 1'b1;
    p0 = n_pkts;
    ar(8'd3);
    t0 = cyc;
    for (int i = 0; i < 4; i++) send_beat(6'd5, 64'h10 + 64'(i), i == 3, 2'd0);
    check("burst_cycles", 128'(cyc - t0), 128'(4));
    drain();
    chk_lat = 1'b0;
    check("normal_pkts", 128'(n_pkts - p0), 128'(4));
    check("normal_flags", 128'({err_resp, err_proto}), 128'(0));

    // backpressure
    p0 = n_pkts;
    yumi_en = 1'b0;
    ar(8'd7);
    for (int i = 0; i < 2; i++) send_beat(6'd3, 64'h20 + 64'(i), 1'b0, 2'd0);
    @(negedge clk);
    check("ready_full", 128'(r_ready), 128'(0));
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        yumi_en = 1'b1;
      end
    join_none
    @(posedge clk);
    #1;
    for (int i = 2; i < 8; i++) send_beat(6'd3, 64'h20 + 64'(i), i == 7, 2'd0);
    drain();
    check("bp_pkts", 128'(n_pkts - p0), 128'(8));
    check("bp_flags", 128'({err_resp, err_proto}), 128'(0));

    // early last, then a clean single-beat burst
    p0 = n_pkts;
    ar(8'd3);
    send_beat(6'd7, 64'h30, 1'b0, 2'd0);
    send_beat(6'd7, 64'h31, 1'b1, 2'd0);
    @(negedge clk);
    check("early_last_proto", 128'({err_resp, err_proto}), 128'(2'b01));
    @(posedge clk);
    #1;
    ar(8'd0);
    send_beat(6'd8, 64'h40, 1'b1, 2'd0);
    drain();
    check("early_last_pkts", 128'(n_pkts - p0), 128'(3));
    lq_empty_probe("early_last");
    do_reset();

    // missing last with error response
    ar(8'd1);
    send_beat(6'd9, 64'h50, 1'b0, 2'd0);
    send_beat(6'd9, 64'h51, 1'b0, 2'd2);
    @(negedge clk);
    check("missing_last_flags", 128'({err_resp, err_proto}), 128'(2'b11));
    @(posedge clk);
    #1;
    drain();
    lq_empty_probe("missing_last");
    do_reset();

    // queue overflow
    repeat (4) ar(8'd0);
    check("full_credit", 128'(ar_credit), 128'(0));
    check("full_no_err", 128'(err_proto), 128'(0));
    ar(8'd0);
    @(negedge clk);
    check("overflow_proto", 128'(err_proto), 128'(1));
    @(posedge clk);
    #1;
    do_reset();

    // push and pop in the same cycle while full
    repeat (4) ar(8'd0);
    ar_fire = 1'b1;
    ar_len  = 8'd0;
    send_beat(6'd1, 64'h60, 1'b1, 2'd0);
    ar_fire = 1'b0;
    check("pushpop_no_err", 128'(err_proto), 128'(0));
    check("pushpop_credit", 128'(ar_credit), 128'(0));
    for (int i = 0; i < 4; i++) send_beat(6'd1, 64'h61 + 64'(i), 1'b1, 2'd0);
    check("pushpop_drained", 128'({ar_credit, err_proto}), 128'(2'b10));
    send_beat(6'd1, 64'h65, 1'b1, 2'd0);
    @(negedge clk);
    check("empty_q_beat", 128'(err_proto), 128'(1));
    @(posedge clk);
    #1;
    drain();
    do_reset();

    // mid-burst reset
    yumi_en = 1'b0;
    ar(8'd7);
    send_beat(6'd2, 64'h70, 1'b0, 2'd1);
    send_beat(6'd2, 64'h71, 1'b0, 2'd0);
    @(negedge clk);
    check("pre_reset", 128'({resp_valid, r_ready, err_resp}), 128'(3'b101));
    @(posedge clk);
    #1;
    do_reset();
    yumi_en = 1'b1;
    p0 = n_pkts;
    ar(8'd0);
    send_beat(6'd4, 64'h80, 1'b1, 2'd0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("after_reset_pkts", 128'(n_pkts - p0), 128'(1));
    check("after_reset_flags", 128'({err_resp, err_proto, ar_credit}), 128'(3'b001));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
